pipe_stage_ctrl: RTL and testbench
==================================

# pipe_stage_ctrl

Flow-controlled pipeline stage controller that sequences the 64-bit pipeline registers between CPU stages. It provides a valid/ready handshake, a second skid register so that a registered `in_ready` loses no throughput, and a synchronous flush for branch mispredicts and exceptions. It sits between adjacent stages, for example IF/ID or ID/EX, in place of a bare register bank. The hazard unit drives `out_ready` (stall) and `flush`.

## Interface
- `WIDTH`, default 64: payload width in bits.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: upstream presents `in_data`.
- `in_ready` output 1: stage can accept. Driven straight from a flop.
- `in_data` input WIDTH: upstream payload.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: downstream accepts. Low means stall.
- `out_data` output WIDTH: payload, driven from the main register.
- `flush` input 1: discard all held entries.
- `stall_cycles` output 32: present only with `PIPE_STAGE_STATS_EN`; see Configuration.

## Operation
- Storage: main register `M` and skid register `S`, each WIDTH bits.
- FSM states:
  - EMPTY: nothing held.
  - ONE: `M` holds valid data.
  - TWO: `M` and `S` both hold valid data.
- Transfers:
  - in_fire = `in_valid` && `in_ready`.
  - out_fire = `out_valid` && `out_ready`.
- Outputs:
  - `out_valid` = (state != EMPTY).
  - `out_data` = `M`.
  - `in_ready` = registered (next_state != TWO).
- Transitions when `flush` = 0:
  - EMPTY, in_fire: go to ONE, `M` <= `in_data`.
  - ONE, in_fire and out_fire: stay in ONE, `M` <= `in_data`.
  - ONE, in_fire only: go to TWO, `S` <= `in_data`.
  - ONE, out_fire only: go to EMPTY.
  - TWO, out_fire: go to ONE, `M` <= `S`. in_fire cannot occur because `in_ready` = 0.
  - Any other case: hold state and data.
- Flush: next state is EMPTY and `in_ready` <= 1.
  - Any in_fire and any out_fire in the same cycle are ignored for state purposes; the beat is dropped.
  - Flush has priority over every other event.
  - `M` and `S` contents are don't-care after flush. They are not cleared.
- Ordering: strict FIFO. Data leaves `S` only through `M`, never directly.
- Width: `M` and `S` are exactly WIDTH bits. There is no arithmetic on the payload.

## Timing
- Reset values: state EMPTY, `out_valid` = 0, `in_ready` = 1, `out_data` = 0 (`M` = 0, `S` = 0). `stall_cycles` = 0 when present.
- Latency: a beat accepted at edge N appears on `out_data` with `out_valid` = 1 after edge N.
- Throughput: one beat per cycle while `out_ready` = 1.
- Backpressure:
  - One beat after `out_ready` falls, the stage absorbs one extra beat into `S`.
  - `in_ready` drops after the edge that fills `S`.
  - `in_ready` rises after the edge where `M` drains while in TWO.
- Reset mid-operation: all held data is discarded and all outputs return to their reset values after the edge. Reset overrides `flush`.
- No combinational path runs from `out_ready` to `in_ready`.

## Configuration
- Macro: `PIPE_STAGE_STATS_EN`.
- Defined:
  - Adds the `stall_cycles` output.
  - Increments it on every cycle with `out_valid` = 1 and `out_ready` = 0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by `reset`; `flush` does not clear it.
- Undefined:
  - The port and counter logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset: assert `reset` for 2 cycles with `in_valid` = 1 → `out_valid` = 0, `in_ready` = 1, `out_data` = 0.
- Streaming: `out_ready` = 1, send 64'h1, 64'h2, 64'h3 on consecutive cycles → `out_data` shows the same sequence one cycle later, with `in_ready` held at 1.
- Backpressure:
  - Send A and B back-to-back, with `out_ready` = 0 from the cycle A becomes valid → state TWO, `in_ready` = 0, `out_data` = A.
  - Then raise `out_ready` → A, then B, each on its own cycle. `in_ready` = 1 after A drains. No beat is lost or duplicated.
- Flush in TWO with `in_valid` = 1 → next cycle `out_valid` = 0 and `in_ready` = 1, and the offered beat is not captured.
- Reset mid-stream in state ONE → next cycle `out_valid` = 0 and `out_data` = 0.
- With `PIPE_STAGE_STATS_EN`:
  - 5 stalled cycles → `stall_cycles` = 5.
  - A flush afterwards leaves `stall_cycles` at 5.
  - A counter preloaded to 32'hFFFF_FFFE and stalled for 3 cycles → 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_stage_ctrl_if.sv
// Valid/ready handshake bundle between two pipeline stages plus the hazard-unit flush.
// master = upstream/downstream/hazard environment, slave = the stage controller.
interface pipe_stage_ctrl_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             flush;

   modport master (
      output in_valid, in_data, out_ready, flush,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready, flush,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Two-entry (main + skid) pipeline stage with registered in_ready and synchronous flush.
// Optional stall statistics counter enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_ctrl #(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               reset,
   pipe_stage_ctrl_if.slave   bus
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [31:0]        stall_cycles
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             in_ready_q;
   logic             in_fire, out_fire;

   assign bus.out_valid = (state_q != EMPTY);
   assign bus.out_data  = m_q;
   assign bus.in_ready  = in_ready_q;

   assign in_fire  = bus.in_valid & in_ready_q;
   assign out_fire = bus.out_valid & bus.out_ready;

   // NOTE: every variable gets a default before the case, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      if (bus.flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = ONE;
                  m_d     = bus.in_data;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  m_d = bus.in_data;
               end else if (in_fire) begin
                  state_d = TWO;
                  s_d     = bus.in_data;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               // Skid data only ever reaches the output by moving through M.
               if (out_fire) begin
                  state_d = ONE;
                  m_d     = s_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= EMPTY;
         m_q        <= '0;
         s_q        <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         m_q        <= m_d;
         s_q        <= s_d;
         // Registered from next state, so out_ready never reaches in_ready combinationally.
         in_ready_q <= (state_d != TWO);
      end
   end

`ifdef PIPE_STAGE_STATS_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else if (bus.out_valid && !bus.out_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl: scoreboard monitor plus per-scenario tasks.
module tb_pipe_stage_ctrl;
   localparam int WIDTH = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipe_stage_ctrl_if #(.WIDTH(WIDTH)) bus ();

`ifdef PIPE_STAGE_STATS_EN
   logic [31:0] stall_cycles;
`endif

   pipe_stage_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
`ifdef PIPE_STAGE_STATS_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   int               checks = 0;
   int               errors = 0;
   logic [WIDTH-1:0] sb[$];
   logic [WIDTH-1:0] sb_exp;

   // Scoreboard: push accepted beats, pop on every delivered beat; flush/reset drop everything held.
   always @(negedge clk) begin
      if (reset || bus.flush) begin
         sb.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_underflow out_data=%h expected=no beat", bus.out_data);
            end else begin
               sb_exp = sb.pop_front();
               if (bus.out_data !== sb_exp) begin
                  errors++;
                  $display("FAIL sb_order out_data=%h expected=%h", bus.out_data, sb_exp);
               end
            end
         end
         if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data = 64'hDEAD_BEEF_0000_0001;
      repeat (2) tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
      reset = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_capture got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_streaming();
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 64'(i);
         tick();
         checks++; if (bus.out_data !== 64'(i)) begin errors++; $display("FAIL stream_data got=%h exp=%h", bus.out_data, 64'(i)); end
         checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready got=%b exp=1", bus.in_ready); end
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_out_valid got=%b exp=1", bus.out_valid); end
      end
      bus.in_valid = 1'b0;
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", bus.out_valid); end
   endtask

   task automatic fill_two(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = a;
      tick();
      bus.in_data = b;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] a = 64'hAAAA_0000_0000_000A;
      logic [WIDTH-1:0] b = 64'hBBBB_0000_0000_000B;
      fill_two(a, b);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low got=%b exp=0", bus.in_ready); end
      checks++; if (bus.out_data !== a) begin errors++; $display("FAIL bp_hold_a got=%h exp=%h", bus.out_data, a); end
      tick();
      checks++; if (bus.out_data !== a || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_hold got=%h/%b exp=%h/0", bus.out_data, bus.in_ready, a); end
      bus.out_ready = 1'b1;
      tick();
      checks++; if (bus.out_data !== b) begin errors++; $display("FAIL bp_b_next got=%h exp=%h", bus.out_data, b); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_rise got=%b exp=1", bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", bus.out_valid); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_sb_left got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_flush();
      fill_two(64'h1111, 64'h2222);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_two got=%b exp=0", bus.in_ready); end
      bus.flush = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data = 64'h3333;
      tick();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", bus.in_ready); end
      bus.out_ready = 1'b1;
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_beat_captured got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_mid_reset();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = 64'h5555_5555_5555_5555;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_reset_pre got=%b exp=1", bus.out_valid); end
      reset = 1'b1;
      bus.flush = 1'b1;
      tick();
      reset = 1'b0;
      bus.flush = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.out_data !== 64'h0) begin errors++; $display("FAIL mid_reset_data got=%h exp=0", bus.out_data); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got=%b exp=1", bus.in_ready); end
   endtask

`ifdef PIPE_STAGE_STATS_EN
   task automatic test_stats();
      checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL stats_reset got=%0d exp=0", stall_cycles); end
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = 64'h7;
      tick();
      bus.in_valid = 1'b0;
      repeat (5) tick();
      checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL stats_count got=%0d exp=5", stall_cycles); end
      bus.flush = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.flush = 1'b0;
      checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL stats_flush got=%0d exp=5", stall_cycles); end
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = 64'h9;
      tick();
      bus.in_valid = 1'b0;
      force dut.stall_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_q;
      repeat (3) tick();
      checks++; if (stall_cycles !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stats_saturate got=%h exp=ffffffff", stall_cycles); end
      bus.out_ready = 1'b1;
      tick();
   endtask
`endif

   task automatic test_back_to_back();
      int guard;
      for (int i = 0; i < 300; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_data = {$urandom, $urandom};
         bus.out_ready = ($urandom_range(0, 3) != 0);
         tick();
         checks++;
         if (bus.out_valid !== (sb.size() != 0) || bus.in_ready !== (sb.size() < 2)) begin
            errors++;
            $display("FAIL b2b_occupancy valid/ready=%b/%b exp occupancy=%0d", bus.out_valid, bus.in_ready, sb.size());
         end
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      guard = 0;
      while (sb.size() != 0 && guard < 10) begin
         tick();
         guard++;
      end
      checks++; if (sb.size() != 0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain left=%0d out_valid=%b exp 0/0", sb.size(), bus.out_valid); end
   endtask

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      bus.flush = 1'b0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_mid_reset();
`ifdef PIPE_STAGE_STATS_EN
      test_stats();
`endif
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
